// File: rtl/morse_sequencer.sv
// morse_sequencer
// Buffers Morse character codes in a FIFO and keys them out on a single line
// using standard unit timing (dot 1, dash 3, element gap 1, letter gap 3,
// word gap 7 units, one unit = DOT_CYCLES clocks).
//
// Ports:
//   clock       in   system clock, rising edge
//   reset_n     in   synchronous active-low reset
//   char_in     in   5-bit code: 0-25 = A-Z, 26 = word space, 27-31 invalid
//   char_valid  in   write request
//   char_ready  out  FIFO has room (registered count < DEPTH)
//   reject      out  one-cycle pulse for an invalid code offered with valid & ready
//   start       in   begin playback (sampled in IDLE only)
//   abort       in   flush FIFO and stop playback
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse when playback ends with the FIFO empty
//   count       out  FIFO occupancy
//   out         out  registered key line, 1 = tone on
module morse_sequencer #(
  parameter int DEPTH      = 16,
  parameter int DOT_CYCLES = 25000000,
  parameter int CNT_W      = 31
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [4:0]                   char_in,
  input  logic                         char_valid,
  output logic                         char_ready,
  output logic                         reject,
  input  logic                         start,
  input  logic                         abort,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         out
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OCC_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] UNIT_LAST  = CNT_W'(DOT_CYCLES - 1);
  localparam logic [OCC_W-1:0] OCC_FULL   = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ZERO   = OCC_W'(0);
  localparam logic [4:0]       CODE_SPACE = 5'd26;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MARK = 3'd2,
    EGAP = 3'd3,
    LGAP = 3'd4,
    WGAP = 3'd5,
    DONE = 3'd6
  } state_t;

  // Letter table: {length[2:0], pattern[3:0]}; pattern is left-aligned so the
  // current element is always bit 3, 1 = dash.
  function automatic logic [6:0] morse_lut(input logic [4:0] code);
    logic [6:0] entry;
    case (code)
      5'd0:    entry = {3'd2, 4'b0100}; // A .-
      5'd1:    entry = {3'd4, 4'b1000}; // B -...
      5'd2:    entry = {3'd4, 4'b1010}; // C -.-.
      5'd3:    entry = {3'd3, 4'b1000}; // D -..
      5'd4:    entry = {3'd1, 4'b0000}; // E .
      5'd5:    entry = {3'd4, 4'b0010}; // F ..-.
      5'd6:    entry = {3'd3, 4'b1100}; // G --.
      5'd7:    entry = {3'd4, 4'b0000}; // H ....
      5'd8:    entry = {3'd2, 4'b0000}; // I ..
      5'd9:    entry = {3'd4, 4'b0111}; // J .---
      5'd10:   entry = {3'd3, 4'b1010}; // K -.-
      5'd11:   entry = {3'd4, 4'b0100}; // L .-..
      5'd12:   entry = {3'd2, 4'b1100}; // M --
      5'd13:   entry = {3'd2, 4'b1000}; // N -.
      5'd14:   entry = {3'd3, 4'b1110}; // O ---
      5'd15:   entry = {3'd4, 4'b0110}; // P .--.
      5'd16:   entry = {3'd4, 4'b1101}; // Q --.-
      5'd17:   entry = {3'd3, 4'b0100}; // R .-.
      5'd18:   entry = {3'd3, 4'b0000}; // S ...
      5'd19:   entry = {3'd1, 4'b1000}; // T -
      5'd20:   entry = {3'd3, 4'b0010}; // U ..-
      5'd21:   entry = {3'd4, 4'b0001}; // V ...-
      5'd22:   entry = {3'd3, 4'b0110}; // W .--
      5'd23:   entry = {3'd4, 4'b1001}; // X -..-
      5'd24:   entry = {3'd4, 4'b1011}; // Y -.--
      5'd25:   entry = {3'd4, 4'b1100}; // Z --..
      default: entry = {3'd0, 4'b0000}; // space / unused
    endcase
    return entry;
  endfunction

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         units_r;
  logic [1:0]         target_s;
  logic [3:0]         pat_r;
  logic [1:0]         elems_r;
  logic [4:0]         mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [OCC_W-1:0]   count_r;
  logic               out_r, busy_r, done_r, reject_r;

  logic [4:0]         head_s;
  logic [6:0]         lut_s;
  logic               fifo_empty_s, char_ready_s, code_ok_s;
  logic               push_s, pop_s, unit_end_s, last_s, timed_s;

  assign head_s       = mem_r[rd_ptr_r];
  assign lut_s        = morse_lut(head_s);
  assign fifo_empty_s = (count_r == OCC_ZERO);
  assign char_ready_s = (count_r < OCC_FULL);
  assign code_ok_s    = (char_in <= CODE_SPACE);
  assign push_s       = char_valid & char_ready_s & code_ok_s & ~abort;
  assign pop_s        = (state_r == LOAD) & ~abort;
  assign unit_end_s   = (cnt_r == UNIT_LAST);
  assign last_s       = unit_end_s & (units_r == target_s);
  assign timed_s      = (state_r == MARK) | (state_r == EGAP) |
                        (state_r == LGAP) | (state_r == WGAP);

  // Number of units (minus one) the current timed state lasts
  always_comb begin
    target_s = 2'd0;
    case (state_r)
      MARK:    target_s = pat_r[3] ? 2'd2 : 2'd0;
      EGAP:    target_s = 2'd0;
      LGAP:    target_s = 2'd2;
      WGAP:    target_s = 2'd3;
      default: target_s = 2'd0;
    endcase
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_s = state_r;
    if (abort) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !fifo_empty_s) state_s = LOAD;
          else                        state_s = IDLE;
        end
        LOAD: begin
          if (head_s == CODE_SPACE) state_s = WGAP;
          else                      state_s = MARK;
        end
        MARK: begin
          if (!last_s)                state_s = MARK;
          else if (elems_r != 2'd0)   state_s = EGAP;
          else if (!fifo_empty_s)     state_s = LGAP;
          else                        state_s = DONE;
        end
        EGAP: begin
          if (last_s) state_s = MARK;
          else        state_s = EGAP;
        end
        LGAP: begin
          if (last_s) state_s = LOAD;
          else        state_s = LGAP;
        end
        WGAP: begin
          if (!last_s)           state_s = WGAP;
          else if (fifo_empty_s) state_s = DONE;
          else                   state_s = LOAD;
        end
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register, unit timer (restarts on each state entry) and element tracking
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      units_r <= 2'd0;
      pat_r   <= 4'd0;
      elems_r <= 2'd0;
    end else begin
      state_r <= state_s;
      if (state_s != state_r || !timed_s) begin
        cnt_r   <= '0;
        units_r <= 2'd0;
      end else if (unit_end_s) begin
        cnt_r   <= '0;
        units_r <= units_r + 2'd1;
      end else begin
        cnt_r   <= cnt_r + CNT_W'(1);
      end
      if (pop_s) begin
        pat_r   <= lut_s[3:0];
        elems_r <= 2'(lut_s[6:4] - 3'd1);
      end else if (state_r == EGAP && last_s) begin
        pat_r   <= {pat_r[2:0], 1'b0};
        elems_r <= elems_r - 2'd1;
      end
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle cancel in count
  always_ff @(posedge clock) begin
    if (!reset_n || abort) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= OCC_ZERO;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + OCC_W'(1);
        2'b01:   count_r <= count_r - OCC_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage (no reset needed, contents are qualified by the pointers)
  always_ff @(posedge clock) begin
    if (reset_n && push_s) mem_r[wr_ptr_r] <= char_in;
  end

  // Registered outputs, derived from the state being entered
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      reject_r <= 1'b0;
    end else begin
      out_r    <= (state_s == MARK);
      busy_r   <= (state_s != IDLE);
      done_r   <= (state_s == DONE);
      reject_r <= char_valid & char_ready_s & ~code_ok_s & ~abort;
    end
  end

  assign out        = out_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign reject     = reject_r;
  assign count      = count_r;
  assign char_ready = char_ready_s;

endmodule

// File: tb/tb_morse_sequencer.sv
// Self-checking bench for morse_sequencer (DEPTH=4, DOT_CYCLES=4).
// Playback expectations are built from a Morse string table and the unit
// timing rules, queued before start, and compared cycle by cycle.
module tb_morse_sequencer;
  localparam int DEPTH = 4;
  localparam int D     = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [4:0]    char_in = 5'd0;
  logic          char_valid = 1'b0;
  logic          char_ready;
  logic          reject;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] count;
  logic          out;

  int checks = 0;
  int failures = 0;

  typedef struct packed { logic o; logic b; logic d; } exp_t;
  exp_t exp_q[$];

  string morse [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....",
                        "..", ".---", "-.-", ".-..", "--", "-.", "---", ".--.",
                        "--.-", ".-.", "...", "-", "..-", "...-", ".--", "-..-",
                        "-.--", "--.."};

  morse_sequencer #(.DEPTH(DEPTH), .DOT_CYCLES(D), .CNT_W(3)) dut (
    .clock(clock), .reset_n(reset_n), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .reject(reject), .start(start), .abort(abort),
    .busy(busy), .done(done), .count(count), .out(out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [4:0] code_of(input byte ch);
    if (ch == 8'd32) return 5'd26;
    else             return 5'(ch - 8'd65);
  endfunction

  task automatic push_char(input logic [4:0] c, output logic rej);
    char_in    = c;
    char_valid = 1'b1;
    tick();
    rej        = reject;
    char_valid = 1'b0;
  endtask

  task automatic add(input logic o, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back('{o: o, b: 1'b1, d: 1'b0});
  endtask

  task automatic build_expected(input string msg);
    string m;
    logic [4:0] c;
    add(1'b0, 1);                                   // first LOAD
    for (int i = 0; i < msg.len(); i++) begin
      c = code_of(msg[i]);
      if (c == 5'd26) begin
        add(1'b0, 4 * D);                           // word-space gap
      end else begin
        m = morse[c];
        for (int j = 0; j < m.len(); j++) begin
          add(1'b1, (m[j] == 8'd45) ? 3 * D : D);
          if (j < m.len() - 1) add(1'b0, D);
        end
        if (i < msg.len() - 1) add(1'b0, 3 * D);    // letter gap
      end
      if (i < msg.len() - 1) add(1'b0, 1);          // next LOAD
    end
    exp_q.push_back('{o: 1'b0, b: 1'b1, d: 1'b1});  // DONE
    exp_q.push_back('{o: 1'b0, b: 1'b0, d: 1'b0});  // back in IDLE
  endtask

  task automatic run_message(input string name, input string msg);
    logic rej;
    exp_t e;
    int cyc;
    for (int i = 0; i < msg.len(); i++) push_char(code_of(msg[i]), rej);
    build_expected(msg);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({out, busy, done} !== e) begin
        failures++;
        $display("FAIL %s cycle %0d: got out=%b busy=%b done=%b, want out=%b busy=%b done=%b",
                 name, cyc, out, busy, done, e.o, e.b, e.d);
      end
      cyc++;
      tick();
    end
    checks++;
    if (count !== CW'(0)) begin
      failures++;
      $display("FAIL %s_count: got %0d want 0", name, count);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({out, busy, done, reject, char_ready} !== 5'b00001 || count !== CW'(0)) begin
      failures++;
      $display("FAIL reset: got out=%b busy=%b done=%b reject=%b ready=%b count=%0d, want 0 0 0 0 1 0",
               out, busy, done, reject, char_ready, count);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_start_empty();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (busy !== 1'b0 || out !== 1'b0) begin
        failures++;
        $display("FAIL start_empty: got busy=%b out=%b want 0 0", busy, out);
      end
      tick();
    end
  endtask

  task automatic test_fill();
    logic rej;
    int rejects = 0;
    push_char(5'd29, rej);
    if (rej) rejects++;
    for (int i = 0; i < 5; i++) begin
      push_char(5'(i), rej);
      if (rej) rejects++;
    end
    checks++;
    if (count !== CW'(4) || char_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill: got count=%0d ready=%b want 4 0", count, char_ready);
    end
    checks++;
    if (rejects != 1) begin
      failures++;
      $display("FAIL fill_reject: got %0d pulses want 1", rejects);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (count !== CW'(0) || char_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_flush: got count=%0d ready=%b want 0 1", count, char_ready);
    end
  endtask

  // Starts "OMT", tops the FIFO up during playback, then stops it mid-dash
  // with abort (use_reset=0) or reset_n (use_reset=1).
  task automatic test_stop(input bit use_reset);
    logic rej;
    int bad_done = 0;
    int bad_out = 0;
    push_char(5'd14, rej);
    push_char(5'd12, rej);
    push_char(5'd19, rej);
    start = 1'b1;
    tick();
    start = 1'b0;
    char_in = 5'd4;
    char_valid = 1'b1;
    tick();                                   // pop of O and push of E together
    checks++;
    if (count !== CW'(3) || out !== 1'b1) begin
      failures++;
      $display("FAIL stop_pushpop: got count=%0d out=%b want 3 1", count, out);
    end
    if (use_reset) begin
      tick();
      char_valid = 1'b0;
      checks++;
      if (count !== CW'(4) || char_ready !== 1'b0) begin
        failures++;
        $display("FAIL stop_full: got count=%0d ready=%b want 4 0", count, char_ready);
      end
      repeat (3) tick();
      reset_n = 1'b0;
    end else begin
      char_valid = 1'b0;
      repeat (4) tick();
      char_valid = 1'b1;                      // discarded by the abort
      abort = 1'b1;
    end
    checks++;
    if (out !== 1'b1) begin
      failures++;
      $display("FAIL stop_middash: got out=%b want 1", out);
    end
    tick();
    abort = 1'b0;
    char_valid = 1'b0;
    checks++;
    if ({out, busy, done, reject, char_ready} !== 5'b00001 || count !== CW'(0)) begin
      failures++;
      $display("FAIL stop_%0d: got out=%b busy=%b done=%b reject=%b ready=%b count=%0d, want 0 0 0 0 1 0",
               use_reset, out, busy, done, reject, char_ready, count);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done !== 1'b0) bad_done++;
      if (out !== 1'b0 || busy !== 1'b0) bad_out++;
    end
    checks++;
    if (bad_done != 0) begin
      failures++;
      $display("FAIL stop_nodone: got %0d done cycles want 0", bad_done);
    end
    checks++;
    if (bad_out != 0) begin
      failures++;
      $display("FAIL stop_quiet: got %0d active cycles want 0", bad_out);
    end
  endtask

  initial begin
    test_reset();
    test_start_empty();
    run_message("letter_e", "E");
    run_message("letter_a", "A");
    run_message("two_letters", "AB");
    run_message("word_space", "E T");
    run_message("mixed", "QZ");
    test_fill();
    test_stop(1'b0);
    test_stop(1'b1);
    run_message("after_stop", "SOS");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/morse_sequencer.md
# morse_sequencer

Parametrised Morse transmitter. Buffers a message of character codes in an internal FIFO and plays it on a single-bit key line (`out`) with standard Morse unit timing: dot 1, dash 3, element gap 1, letter gap 3, word gap 7. It is the successor to the fixed 11-letter shift-register player. It adds configurable depth and unit length, word spaces, a ready/valid write port, abort, and a completion pulse. It sits between the keypad/switch front end and the LED/buzzer driver.

## Interface
- `DEPTH`, 16: FIFO capacity in characters; power of two, ≥2.
- `DOT_CYCLES`, 25000000: clocks per Morse unit; ≥1.
- `CNT_W`, 31: width of the unit counter; must hold `DOT_CYCLES-1`.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  reset: synchronous, active-low.
- `char_in`  in  5  character code. 0–25 = A–Z. 26 = word space. 27–31 invalid.
- `char_valid`  in  1  write request.
- `char_ready`  out  1  high when FIFO count < DEPTH.
- `reject`  out  1  one-cycle pulse when an invalid code is offered with valid & ready.
- `start`  in  1  begin playback; sampled only in IDLE.
- `abort`  in  1  flush FIFO, stop playback.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when playback ends with the FIFO empty.
- `count`  out  $clog2(DEPTH+1)  current FIFO occupancy.
- `out`  out  1  key line, registered; 1 = tone/LED on.

## Operation
- Reset values: `out`=0, `busy`=0, `done`=0, `reject`=0, `count`=0, `char_ready`=1. State is IDLE and the unit counter is cleared.
- Write: valid & ready & code ≤26 pushes `char_in`. Codes 27–31 are not stored and pulse `reject` instead. Writes are legal in any state, including during playback.
- Simultaneous push and pop in one cycle: both take effect and `count` is unchanged. `char_ready` is computed from the registered count only.
- Internal LUT maps each letter to length L (1–4) and an element pattern, MSB first, 1 = dash. Example: A = L2 ".-"; Q = L4 "--.-".
- FSM states: IDLE, LOAD, MARK, EGAP, LGAP, WGAP, DONE.
  - IDLE: if `start` & count>0, go to LOAD. `start` with an empty FIFO is ignored.
  - LOAD: pop the head.
    - Letter: latch pattern and L, element index = 0, go to MARK.
    - Space: go to WGAP.
  - MARK: `out`=1 for 1 unit (dot) or 3 units (dash). Then:
    - more elements remain: EGAP;
    - last element and FIFO non-empty: LGAP;
    - last element and FIFO empty: DONE.
  - EGAP: `out`=0 for 1 unit, advance element index, go to MARK.
  - LGAP: `out`=0 for 3 units, go to LOAD.
  - WGAP: `out`=0 for 4 units. Combined with the preceding LGAP this gives 7 units. Then LOAD if the FIFO is non-empty, else DONE.
  - DONE: `done`=1 for one cycle, go to IDLE.
- The FIFO-empty check at the end of MARK/WGAP uses `count` in that cycle. A character written in the same cycle is not seen; it stays buffered for the next `start`.
- `abort` (any state, priority over everything except reset): next cycle `out`=0, IDLE, `count`=0, no `done`. A push in the same cycle as `abort` is discarded.
- Reset mid-playback behaves like abort and also returns every output to its reset value.

## Timing
- The unit counter reloads on every state entry. One unit is exactly `DOT_CYCLES` clocks.
- `start` sampled at edge t: LOAD at t+1, first MARK at t+2, and `out` is 1 from edge t+2.
- Mark/gap durations are exact clock multiples: dot = D, dash = 3D, element gap = D, letter gap = 3D, word-space gap = 4D, where D = `DOT_CYCLES`.
- Between letters, the LGAP→LOAD→MARK path adds one extra low clock (the LOAD cycle). Letter gap observed on `out` = 3D+1.
- `done` asserts the cycle after the final mark or gap ends. `busy` falls one cycle after that.
- FIFO pointers wrap modulo DEPTH. Full means count = DEPTH; at full, `char_ready`=0 and pushes are ignored.

## Test plan
- DOT_CYCLES=4, write "E", start → `out` high 4 clocks starting 2 cycles after start, then `done` pulse; `busy` spans start+1 … done.
- Write "A" → `out` pattern 1×4, 0×4, 1×12, then `done`.
- Write "A","B" → after A's dash, `out` is low 13 clocks (3D+1), then B ("-...") begins with 12 high clocks.
- Write "E", space, "T" → `out` is low 12+1+16+1 clocks between E's dot and T's dash.
- DEPTH=4: push 5 valid codes plus code 29 while idle → `count`=4, `char_ready`=0, 5th push dropped, `reject` pulses once for 29.
- Start a 3-letter message, assert `abort` mid-dash → next cycle `out`=0, `busy`=0, `count`=0, no `done`. Repeat with `reset_n`=0 instead → same result plus `char_ready`=1.
